// File: rtl/psum_xchg_pkg.sv
// Shared constants and width helpers for the
// partial-sum exchange unit.
package psum_xchg_pkg;

  localparam logic MODE_SWAP   = 1'b0;
  localparam logic MODE_REDUCE = 1'b1;

  function automatic int calc_ow(int bw, int n);
    return bw + $clog2(n);
  endfunction

  function automatic int calc_pw(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/psum_xchg_if.sv
// Core-side bundle of the partial-sum exchange
// unit: push/request strobes in, sums and flags out.
interface psum_xchg_if
  import psum_xchg_pkg::*;
#(
  parameter int NCORE  = 2,
  parameter int BW_SUM = 24,
  parameter int OW     = calc_ow(BW_SUM, NCORE)
);
  logic                    mode;
  logic [NCORE-1:0]        wr_en;
  logic [NCORE*BW_SUM-1:0] sum_in;
  logic [NCORE-1:0]        rd_en;
  logic [NCORE*OW-1:0]     sum_out;
  logic [NCORE-1:0]        out_valid;
  logic [NCORE-1:0]        full;
  logic [NCORE-1:0]        pend;
  logic [NCORE-1:0]        ovf;

  modport master (
    output mode, wr_en, sum_in, rd_en,
    input  sum_out, out_valid, full, pend, ovf
  );

  modport slave (
    input  mode, wr_en, sum_in, rd_en,
    output sum_out, out_valid, full, pend, ovf
  );
endinterface

// File: rtl/psum_xchg_sum_fifo.sv
// Per-core partial-sum FIFO with wrap-around
// pointers; head is combinational from storage.
module sum_fifo
  import psum_xchg_pkg::*;
#(
  parameter  int BW_SUM = 24,
  parameter  int DEPTH  = 8,
  localparam int PW     = calc_pw(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [BW_SUM-1:0] din_i,
  output logic [BW_SUM-1:0] head_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);
  logic [BW_SUM-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rp_q];

  // a full FIFO still accepts when it pops this cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wp_d  = wp_q + PW'(do_push);
    rp_d  = rp_q + PW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/psum_xchg.sv
// Partial-sum exchange: pair-swap or all-reduce
// of per-core FIFO heads back to requesting cores.
module psum_xchg
  import psum_xchg_pkg::*;
#(
  parameter  int NCORE  = 2,
  parameter  int BW_SUM = 24,
  parameter  int DEPTH  = 8,
  localparam int OW     = calc_ow(BW_SUM, NCORE),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  psum_xchg_if.slave  bus
);
  logic [BW_SUM-1:0] head [NCORE];
  logic [OW-1:0]     hext [NCORE];
  logic [OW-1:0]     nxt  [NCORE];
  logic [CW-1:0]     cnt  [NCORE];
  logic [NCORE-1:0]  full, empty;
  logic [NCORE-1:0]  push, pop;
  logic [NCORE-1:0]  req, serve_sw, served;
  logic              serve_all, idle;
  logic [OW-1:0]     sum_all;

  logic              mode_q, mode_d;
  logic [NCORE-1:0]  pend_q, pend_d;
  logic [NCORE-1:0]  ovf_q, ovf_d;
  logic [NCORE-1:0]  vld_q, vld_d;
  logic [NCORE*OW-1:0] sum_q, sum_d;

  assign req       = pend_q | bus.rd_en;
  assign serve_all = (&req) & ~(|empty);
  assign served    = (mode_q == MODE_REDUCE) ?
                     {NCORE{serve_all}} : serve_sw;

  for (genvar i = 0; i < NCORE; i++) begin : g_core
    localparam int P = i ^ 1;

    sum_fifo #(
      .BW_SUM (BW_SUM),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   (bus.sum_in[i*BW_SUM +: BW_SUM]),
      .head_o  (head[i]),
      .count_o (cnt[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );

    assign hext[i] = {{(OW-BW_SUM){head[i][BW_SUM-1]}},
                      head[i]};
    assign serve_sw[i] = req[i] & ~empty[P];
    // in swap mode FIFO i drains toward its partner
    assign pop[i] = (mode_q == MODE_REDUCE) ?
                    serve_all : serve_sw[P];
    assign push[i] = bus.wr_en[i] & (~full[i] | pop[i]);
    assign nxt[i]  = (mode_q == MODE_REDUCE) ?
                     sum_all : hext[P];
  end

  always_comb begin
    sum_all = '0;
    for (int k = 0; k < NCORE; k++) begin
      sum_all = sum_all + hext[k];
    end
  end

  always_comb begin
    idle = ~(|bus.wr_en);
    for (int k = 0; k < NCORE; k++) begin
      if (cnt[k] != '0) idle = 1'b0;
    end
  end

  always_comb begin
    mode_d = idle ? bus.mode : mode_q;
    pend_d = req & ~served;
    ovf_d  = ovf_q | (bus.wr_en & full & ~pop);
    vld_d  = served;
    sum_d  = sum_q;
    for (int k = 0; k < NCORE; k++) begin
      if (served[k]) sum_d[k*OW +: OW] = nxt[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_SWAP;
      pend_q <= '0;
      ovf_q  <= '0;
      vld_q  <= '0;
      sum_q  <= '0;
    end else begin
      mode_q <= mode_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
      sum_q  <= sum_d;
    end
  end

  assign bus.sum_out   = sum_q;
  assign bus.out_valid = vld_q;
  assign bus.full      = full;
  assign bus.pend      = pend_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_psum_xchg.sv
// Directed self-checking bench for psum_xchg
// at NCORE=4, BW_SUM=24, DEPTH=8.
module tb_psum_xchg;
  import psum_xchg_pkg::*;

  localparam int NC = 4;
  localparam int BW = 24;
  localparam int DP = 8;
  localparam int OW = calc_ow(BW, NC);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_xchg_if #(.NCORE(NC), .BW_SUM(BW), .OW(OW)) bus ();

  psum_xchg #(
    .NCORE  (NC),
    .BW_SUM (BW),
    .DEPTH  (DP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  function automatic logic [OW-1:0] so(int i);
    return bus.sum_out[i*OW +: OW];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] we,
                       input logic [NC-1:0] re,
                       input int v0 = 0, input int v1 = 0,
                       input int v2 = 0, input int v3 = 0);
    bus.wr_en  = we;
    bus.rd_en  = re;
    bus.sum_in = {BW'(v3), BW'(v2), BW'(v1), BW'(v0)};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.mode = MODE_SWAP;
    drive('0, '0);
    tick;
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b0 || bus.sum_out !== '0)
      $display("FAIL rst_out got %b/%h want 0/0",
               bus.out_valid, bus.sum_out);
    else pass_cnt++;
    tot_cnt++;
    if ({bus.full, bus.pend, bus.ovf} !== 12'b0)
      $display("FAIL rst_flags got %b/%b/%b want 0",
               bus.full, bus.pend, bus.ovf);
    else pass_cnt++;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_swap;
    drive(4'b0011, 4'b0000, 100, -5);
    tick;
    drive(4'b0000, 4'b0011);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b0011)
      $display("FAIL swap_vld got %b want 0011",
               bus.out_valid);
    else pass_cnt++;
    tot_cnt++;
    if (so(0) !== OW'(-5))
      $display("FAIL swap_so0 got %h want %h",
               so(0), OW'(-5));
    else pass_cnt++;
    tot_cnt++;
    if (so(1) !== OW'(100))
      $display("FAIL swap_so1 got %h want %h",
               so(1), OW'(100));
    else pass_cnt++;
    drive('0, '0);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b0 || so(0) !== OW'(-5))
      $display("FAIL swap_hold got %b/%h want 0/%h",
               bus.out_valid, so(0), OW'(-5));
    else pass_cnt++;
  endtask

  task automatic test_blocked;
    drive('0, 4'b0001);
    tick;
    for (int c = 0; c < 3; c++) begin
      tot_cnt++;
      if (bus.pend !== 4'b0001 || bus.out_valid !== 4'b0)
        $display("FAIL blk_wait%0d got %b/%b want 0001/0000",
                 c, bus.pend, bus.out_valid);
      else pass_cnt++;
      if (c < 2) drive('0, '0);
      else drive(4'b0010, '0, 0, 7);
      tick;
    end
    tot_cnt++;
    if (bus.pend !== 4'b0001 || bus.out_valid !== 4'b0)
      $display("FAIL blk_nobypass got %b/%b want 0001/0000",
               bus.pend, bus.out_valid);
    else pass_cnt++;
    drive('0, '0);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b0001 || so(0) !== OW'(7) ||
        bus.pend !== 4'b0)
      $display("FAIL blk_serve got %b/%h/%b want 0001/%h/0000",
               bus.out_valid, so(0), bus.pend, OW'(7));
    else pass_cnt++;
  endtask

  task automatic test_reduce;
    logic [NC-1:0] ep;
    bus.mode = MODE_REDUCE;
    drive('0, '0);
    tick;
    drive(4'b1111, '0, 1, 2, 3, -10);
    tick;
    for (int s = 0; s < NC; s++) begin
      drive('0, 4'(1 << s));
      tick;
      if (s < NC - 1) begin
        ep = 4'((1 << (s + 1)) - 1);
        tot_cnt++;
        if (bus.out_valid !== 4'b0 || bus.pend !== ep)
          $display("FAIL red_wait%0d got %b/%b want 0000/%b",
                   s, bus.out_valid, bus.pend, ep);
        else pass_cnt++;
      end
    end
    tot_cnt++;
    if (bus.out_valid !== 4'b1111 || bus.pend !== 4'b0)
      $display("FAIL red_vld got %b/%b want 1111/0000",
               bus.out_valid, bus.pend);
    else pass_cnt++;
    for (int i = 0; i < NC; i++) begin
      tot_cnt++;
      if (so(i) !== OW'(-4))
        $display("FAIL red_so%0d got %h want %h",
                 i, so(i), OW'(-4));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    drive(4'b1111, '0, -8388608, -8388608,
          -8388608, -8388608);
    tick;
    drive(4'b1111, '0, 1, 1, 1, 1);
    tick;
    drive('0, 4'b1111);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b1111)
      $display("FAIL b2b_vld0 got %b want 1111",
               bus.out_valid);
    else pass_cnt++;
    for (int i = 0; i < NC; i++) begin
      tot_cnt++;
      if (so(i) !== OW'(-33554432))
        $display("FAIL b2b_min%0d got %h want %h",
                 i, so(i), OW'(-33554432));
      else pass_cnt++;
    end
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b1111 || so(3) !== OW'(4))
      $display("FAIL b2b_second got %b/%h want 1111/%h",
               bus.out_valid, so(3), OW'(4));
    else pass_cnt++;
    drive('0, '0);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b0)
      $display("FAIL b2b_end got %b want 0000",
               bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_mode_gating;
    bus.mode = MODE_SWAP;
    drive('0, '0);
    tick;
    drive(4'b1100, '0, 0, 0, 55, 66);
    tick;
    bus.mode = MODE_REDUCE;
    drive('0, 4'b0100);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b0100 || so(2) !== OW'(66))
      $display("FAIL gate_sw2 got %b/%h want 0100/%h",
               bus.out_valid, so(2), OW'(66));
    else pass_cnt++;
    drive('0, 4'b1000);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b1000 || so(3) !== OW'(55))
      $display("FAIL gate_sw3 got %b/%h want 1000/%h",
               bus.out_valid, so(3), OW'(55));
    else pass_cnt++;
    drive('0, '0);
    tick;
    drive(4'b1111, '0, 5, 5, 5, 5);
    tick;
    drive('0, 4'b1111);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b1111 || so(0) !== OW'(20))
      $display("FAIL gate_red got %b/%h want 1111/%h",
               bus.out_valid, so(0), OW'(20));
    else pass_cnt++;
    drive('0, '0);
    tick;
  endtask

  task automatic test_ovf_wrap;
    int errs;
    bus.mode = MODE_SWAP;
    drive('0, '0);
    tick;
    for (int k = 0; k < DP; k++) begin
      drive(4'b0001, '0, k);
      tick;
    end
    tot_cnt++;
    if (bus.full !== 4'b0001 || bus.ovf !== 4'b0)
      $display("FAIL ovf_fill got %b/%b want 0001/0000",
               bus.full, bus.ovf);
    else pass_cnt++;
    drive(4'b0001, '0, 99);
    tick;
    tot_cnt++;
    if (bus.ovf !== 4'b0001 || bus.full !== 4'b0001)
      $display("FAIL ovf_drop got %b/%b want 0001/0001",
               bus.ovf, bus.full);
    else pass_cnt++;
    errs = 0;
    for (int k = 0; k < 28; k++) begin
      if (k < 20) drive(4'b0001, 4'b0010, DP + k);
      else drive('0, 4'b0010);
      tick;
      if (bus.out_valid !== 4'b0010 || so(1) !== OW'(k)) begin
        $display("FAIL wrap_%0d got %b/%h want 0010/%h",
                 k, bus.out_valid, so(1), OW'(k));
        errs++;
      end
      if (k == 19) begin
        tot_cnt++;
        if (bus.full !== 4'b0001)
          $display("FAIL wrap_full got %b want 0001",
                   bus.full);
        else pass_cnt++;
      end
    end
    tot_cnt++;
    if (errs == 0) pass_cnt++;
    drive('0, '0);
    tick;
    tot_cnt++;
    if (bus.full !== 4'b0 || bus.ovf !== 4'b0001 ||
        bus.pend !== 4'b0)
      $display("FAIL wrap_end got %b/%b/%b want 0/0001/0",
               bus.full, bus.ovf, bus.pend);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    bus.mode = MODE_REDUCE;
    drive('0, '0);
    tick;
    drive(4'b0011, '0, 1, 2);
    tick;
    drive('0, 4'b0100);
    tick;
    tot_cnt++;
    if (bus.pend !== 4'b0100)
      $display("FAIL arst_pre got %b want 0100", bus.pend);
    else pass_cnt++;
    drive('0, '0);
    #2;
    reset = 1'b1;
    #1;
    tot_cnt++;
    if (bus.sum_out !== '0 || bus.out_valid !== 4'b0)
      $display("FAIL arst_out got %h/%b want 0/0",
               bus.sum_out, bus.out_valid);
    else pass_cnt++;
    tot_cnt++;
    if ({bus.full, bus.pend, bus.ovf} !== 12'b0)
      $display("FAIL arst_flags got %b/%b/%b want 0",
               bus.full, bus.pend, bus.ovf);
    else pass_cnt++;
    #1;
    reset = 1'b0;
    drive(4'b0001, 4'b0010, 42);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b0 || bus.pend !== 4'b0010)
      $display("FAIL arst_req got %b/%b want 0000/0010",
               bus.out_valid, bus.pend);
    else pass_cnt++;
    drive('0, '0);
    tick;
    tot_cnt++;
    if (bus.out_valid !== 4'b0010 || so(1) !== OW'(42) ||
        bus.pend !== 4'b0)
      $display("FAIL arst_serve got %b/%h/%b want 0010/%h/0",
               bus.out_valid, so(1), bus.pend, OW'(42));
    else pass_cnt++;
  endtask

  initial begin
    reset    = 1'b1;
    bus.mode = MODE_SWAP;
    drive('0, '0);
    test_reset;
    test_swap;
    test_blocked;
    test_reduce;
    test_back_to_back;
    test_mode_gating;
    test_ovf_wrap;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
